// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception controller.
// Optional feature macro: EXC_COUNTER_EN (adds the ECNT entry counter).
package exc_pkg;

  // Controller state: normal execution or inside the exception handler.
  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  // ESR[3:0] cause codes.
  localparam logic [3:0] CAUSE_INVALID = 4'b0001;
  localparam logic [3:0] CAUSE_IRQ     = 4'b0010;

  // ESR is the 4-bit cause plus the sticky double-fault flag in bit 4.
  localparam int ESR_W = 5;

  // MRS selector codes.
  localparam logic [1:0] SEL_ELR  = 2'b00;
  localparam logic [1:0] SEL_ESR  = 2'b01;
  localparam logic [1:0] SEL_ECNT = 2'b10;
  localparam logic [1:0] SEL_RSVD = 2'b11;

  // Entry counter width.
  localparam int ECNT_W = 16;

  // Saturating increment for the entry counter: holds at all-ones.
  function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] val);
    logic [ECNT_W-1:0] res;
    if (val == {ECNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + {{(ECNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/exc_sysregs.sv
// Exception system registers: ELR, ESR and (with EXC_COUNTER_EN) the ECNT
// entry counter, plus the zero-extending MRS read mux.
// Without EXC_COUNTER_EN there is no ECNT storage and selector 10 reads 0.
module exc_sysregs
  import exc_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         elr_we,
  input  logic [N-1:0] elr_d,
  input  logic         cause_we,
  input  logic [3:0]   cause_d,
  input  logic         dbl_set,
`ifdef EXC_COUNTER_EN
  input  logic         cnt_inc,
`endif
  input  logic [1:0]   sel,
  output logic [N-1:0] elr,
  output logic [N-1:0] rd_data
);

  logic [N-1:0]      elr_r;
  logic [ESR_W-1:0]  esr_r;
  logic [ECNT_W-1:0] ecnt_s;

  // ELR captures the PC of the instruction being abandoned on entry from RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elr_r <= {N{1'b0}};
    end else if (elr_we) begin
      elr_r <= elr_d;
    end
  end

  // ESR: cause field rewritten on a fresh entry, bit 4 sticks once a double fault occurs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      esr_r <= {ESR_W{1'b0}};
    end else begin
      if (cause_we) begin
        esr_r[3:0] <= cause_d;
      end
      if (dbl_set) begin
        esr_r[4] <= 1'b1;
      end
    end
  end

`ifdef EXC_COUNTER_EN
  logic [ECNT_W-1:0] ecnt_r;

  // ECNT counts every handler entry, including double faults, and saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ecnt_r <= {ECNT_W{1'b0}};
    end else if (cnt_inc) begin
      ecnt_r <= sat_inc(ecnt_r);
    end
  end

  assign ecnt_s = ecnt_r;
`else
  assign ecnt_s = {ECNT_W{1'b0}};
`endif

  assign elr = elr_r;

  // MRS read mux, every source zero-extended to the datapath width.
  always_comb begin
    rd_data = {N{1'b0}};
    case (sel)
      SEL_ELR:  rd_data = elr_r;
      SEL_ESR:  rd_data = {{(N-ESR_W){1'b0}}, esr_r};
      SEL_ECNT: rd_data = {{(N-ECNT_W){1'b0}}, ecnt_s};
      SEL_RSVD: rd_data = {N{1'b0}};
      default:  rd_data = {N{1'b0}};
    endcase
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller for the single-cycle LEGv8 core: decides exception
// entry/return in the same cycle, handles the IRQ acknowledge handshake.
// Optional feature macro: EXC_COUNTER_EN (ECNT readable with SysRegSel=10).
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int           N      = 64,
  parameter logic [N-1:0] VECTOR = 64'hD8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ExtIRQ,
  input  logic [N-1:0] PC,
  input  logic [1:0]   SysRegSel,
  output logic         Exc,
  output logic [N-1:0] ExcVector,
  output logic         ERetValid,
  output logic [N-1:0] ERetTarget,
  output logic         ExtIAck,
  output logic         InHandler,
  output logic [N-1:0] SysRegData
);

  state_t     state_r;
  state_t     state_nxt_s;
  logic       exc_s;
  logic       eret_valid_s;
  logic       entry_s;
  logic       irq_take_s;
  logic       dbl_fault_s;
  logic [3:0] cause_s;
  logic       ack_r;
  logic [N-1:0] elr_s;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: enter on fault/IRQ from RUN, leave on ERET from HANDLER.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (NotAnInstr || ExtIRQ) begin
          state_nxt_s = HANDLER;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HANDLER: begin
        if (ERet && !NotAnInstr) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = HANDLER;
        end
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // Decisions for this cycle; an undecodable opcode beats a simultaneous IRQ,
  // and the IRQ is masked while in the handler.
  always_comb begin
    exc_s        = 1'b0;
    eret_valid_s = 1'b0;
    entry_s      = 1'b0;
    irq_take_s   = 1'b0;
    dbl_fault_s  = 1'b0;
    cause_s      = CAUSE_INVALID;
    if (reset) begin
      exc_s = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (NotAnInstr) begin
            exc_s   = 1'b1;
            entry_s = 1'b1;
            cause_s = CAUSE_INVALID;
          end else if (ExtIRQ) begin
            exc_s      = 1'b1;
            entry_s    = 1'b1;
            irq_take_s = 1'b1;
            cause_s    = CAUSE_IRQ;
          end else begin
            exc_s = 1'b0;
          end
        end
        HANDLER: begin
          if (NotAnInstr) begin
            exc_s       = 1'b1;
            dbl_fault_s = 1'b1;
          end else if (ERet) begin
            eret_valid_s = 1'b1;
          end else begin
            exc_s = 1'b0;
          end
        end
        default: exc_s = 1'b0;
      endcase
    end
  end

  // IRQ acknowledge: one registered pulse in the cycle after an IRQ entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= irq_take_s;
    end
  end

  exc_sysregs #(
    .N(N)
  ) u_sysregs (
    .clk      (clk),
    .reset    (reset),
    .elr_we   (entry_s),
    .elr_d    (PC),
    .cause_we (entry_s),
    .cause_d  (cause_s),
    .dbl_set  (dbl_fault_s),
`ifdef EXC_COUNTER_EN
    .cnt_inc  (exc_s),
`endif
    .sel      (SysRegSel),
    .elr      (elr_s),
    .rd_data  (SysRegData)
  );

  assign Exc        = exc_s;
  assign ExcVector  = VECTOR;
  assign ERetValid  = eret_valid_s;
  assign ERetTarget = elr_s;
  assign ExtIAck    = ack_r;
  assign InHandler  = (state_r == HANDLER);

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl; inputs change on the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_exception_ctrl;

  logic        clk;
  logic        reset;
  logic        NotAnInstr;
  logic        ERet;
  logic        ExtIRQ;
  logic [63:0] PC;
  logic [1:0]  SysRegSel;
  logic        Exc;
  logic [63:0] ExcVector;
  logic        ERetValid;
  logic [63:0] ERetTarget;
  logic        ExtIAck;
  logic        InHandler;
  logic [63:0] SysRegData;

  int n_asserts;
  int n_fail;

  exception_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .NotAnInstr (NotAnInstr),
    .ERet       (ERet),
    .ExtIRQ     (ExtIRQ),
    .PC         (PC),
    .SysRegSel  (SysRegSel),
    .Exc        (Exc),
    .ExcVector  (ExcVector),
    .ERetValid  (ERetValid),
    .ERetTarget (ERetTarget),
    .ExtIAck    (ExtIAck),
    .InHandler  (InHandler),
    .SysRegData (SysRegData)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Expected ECNT value after n entries, depending on build configuration.
  function automatic logic [63:0] ecnt_exp(input int n);
`ifdef EXC_COUNTER_EN
    return 64'(n);
`else
    return 64'(n - n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Read one system register through the MRS port and compare.
  task automatic rd(input logic [1:0] sel, input logic [63:0] exp, input string tag);
    SysRegSel = sel;
    #1;
    chk(tag, SysRegData, exp);
  endtask

  initial begin
    n_asserts  = 0;
    n_fail     = 0;
    reset      = 1'b1;
    NotAnInstr = 1'b0;
    ERet       = 1'b0;
    ExtIRQ     = 1'b0;
    PC         = 64'h0;
    SysRegSel  = 2'b00;

    // Reset state.
    nxt(); nxt(); #1;
    chk("rst_exc", {63'd0, Exc}, 64'd0);
    chk("rst_inh", {63'd0, InHandler}, 64'd0);
    chk("rst_ack", {63'd0, ExtIAck}, 64'd0);
    chk("vector", ExcVector, 64'hD8);
    reset = 1'b0;

    // Invalid opcode in RUN.
    nxt(); PC = 64'h40; NotAnInstr = 1'b1; #1;
    chk("t2_exc", {63'd0, Exc}, 64'd1);
    chk("t2_eretv", {63'd0, ERetValid}, 64'd0);
    nxt(); NotAnInstr = 1'b0; PC = 64'hD8; #1;
    chk("t2_inh", {63'd0, InHandler}, 64'd1);
    chk("t2_ack", {63'd0, ExtIAck}, 64'd0);
    rd(2'b00, 64'h40, "t2_elr");
    rd(2'b01, 64'h01, "t2_esr");
    rd(2'b10, ecnt_exp(1), "t2_ecnt");
    ERet = 1'b1; #1;
    chk("t2_eretv1", {63'd0, ERetValid}, 64'd1);
    chk("t2_eret_tgt", ERetTarget, 64'h40);
    nxt(); ERet = 1'b0; #1;
    chk("t2_ret_inh", {63'd0, InHandler}, 64'd0);

    // Fault and IRQ together: fault wins, IRQ stays pending and is taken after return.
    nxt(); PC = 64'h80; NotAnInstr = 1'b1; ExtIRQ = 1'b1; #1;
    chk("t3_exc", {63'd0, Exc}, 64'd1);
    nxt(); NotAnInstr = 1'b0; PC = 64'hD8; #1;
    chk("t3_ack0", {63'd0, ExtIAck}, 64'd0);
    chk("t3_masked", {63'd0, Exc}, 64'd0);
    rd(2'b01, 64'h01, "t3_esr");
    rd(2'b00, 64'h80, "t3_elr");
    ERet = 1'b1; PC = 64'h200; #1;
    chk("t3_eretv", {63'd0, ERetValid}, 64'd1);
    chk("t3_tgt", ERetTarget, 64'h80);
    nxt(); ERet = 1'b0; PC = 64'h84; #1;
    chk("t3_irq_exc", {63'd0, Exc}, 64'd1);
    nxt(); ExtIRQ = 1'b0; PC = 64'hD8; #1;
    chk("t3_ack1", {63'd0, ExtIAck}, 64'd1);
    rd(2'b01, 64'h02, "t3_esr_irq");
    rd(2'b00, 64'h84, "t3_elr_irq");
    nxt(); #1;
    chk("t3_ack_pulse", {63'd0, ExtIAck}, 64'd0);
    ERet = 1'b1;
    nxt(); ERet = 1'b0; #1;
    chk("t3_ret_inh", {63'd0, InHandler}, 64'd0);
    rd(2'b10, ecnt_exp(3), "t3_ecnt");

    // Plain IRQ entry and return.
    nxt(); PC = 64'h100; ExtIRQ = 1'b1; #1;
    chk("t4_exc", {63'd0, Exc}, 64'd1);
    nxt(); ExtIRQ = 1'b0; PC = 64'hD8; #1;
    chk("t4_ack1", {63'd0, ExtIAck}, 64'd1);
    chk("t4_inh", {63'd0, InHandler}, 64'd1);
    nxt(); ERet = 1'b1; #1;
    chk("t4_ack0", {63'd0, ExtIAck}, 64'd0);
    chk("t4_eretv", {63'd0, ERetValid}, 64'd1);
    chk("t4_tgt", ERetTarget, 64'h100);
    nxt(); ERet = 1'b0; PC = 64'h104; #1;
    chk("t4_ret_inh", {63'd0, InHandler}, 64'd0);

    // IRQ masked in handler, then a double fault.
    nxt(); PC = 64'h300; NotAnInstr = 1'b1; #1;
    chk("t5_entry", {63'd0, Exc}, 64'd1);
    nxt(); NotAnInstr = 1'b0; ExtIRQ = 1'b1; PC = 64'hD8;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_mask_exc", {63'd0, Exc}, 64'd0);
      chk("t5_mask_ack", {63'd0, ExtIAck}, 64'd0);
      nxt();
    end
    PC = 64'hE0; NotAnInstr = 1'b1; #1;
    chk("t5_dbl_exc", {63'd0, Exc}, 64'd1);
    nxt(); NotAnInstr = 1'b0; ExtIRQ = 1'b0; PC = 64'hD8; #1;
    chk("t5_inh", {63'd0, InHandler}, 64'd1);
    rd(2'b01, 64'h11, "t5_esr");
    rd(2'b00, 64'h300, "t5_elr");
    rd(2'b10, ecnt_exp(6), "t5_ecnt");
    ERet = 1'b1;
    nxt(); ERet = 1'b0; #1;
    chk("t5_ret_inh", {63'd0, InHandler}, 64'd0);

    // ERET in RUN is ignored.
    nxt(); PC = 64'h500; ERet = 1'b1; #1;
    chk("t6_eretv", {63'd0, ERetValid}, 64'd0);
    chk("t6_exc", {63'd0, Exc}, 64'd0);
    nxt(); ERet = 1'b0; #1;
    chk("t6_inh", {63'd0, InHandler}, 64'd0);
    rd(2'b00, 64'h300, "t6_elr");
    rd(2'b01, 64'h11, "t6_esr");
    rd(2'b10, ecnt_exp(6), "t6_ecnt");
    rd(2'b11, 64'h0, "t6_rsvd");

    // Reset asserted mid-handler while the ack pulse is high.
    nxt(); PC = 64'h600; ExtIRQ = 1'b1;
    nxt(); ExtIRQ = 1'b0; #1;
    chk("t1_ack_pre", {63'd0, ExtIAck}, 64'd1);
    chk("t1_inh_pre", {63'd0, InHandler}, 64'd1);
    NotAnInstr = 1'b1; reset = 1'b1; #1;
    chk("t1_inh", {63'd0, InHandler}, 64'd0);
    chk("t1_exc", {63'd0, Exc}, 64'd0);
    chk("t1_ack", {63'd0, ExtIAck}, 64'd0);
    rd(2'b00, 64'h0, "t1_elr");
    rd(2'b01, 64'h0, "t1_esr");
    rd(2'b10, 64'h0, "t1_ecnt");
    NotAnInstr = 1'b0;
    nxt(); reset = 1'b0;
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
